// File: rtl/sfifo_packet.sv
// Store-and-forward packet FIFO: a packet becomes readable only once its last
// beat is written; partial packets can be aborted or dropped on overflow by
// rolling the write pointer back to the last commit point.
module sfifo_packet #(
  parameter int unsigned BW     = 64,
  parameter int unsigned LGFLEN = 9
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              S_VALID,
  output logic              S_READY,
  input  logic [BW-1:0]     S_DATA,
  input  logic              S_LAST,
  input  logic              S_ABORT,
  output logic              M_VALID,
  input  logic              M_READY,
  output logic [BW-1:0]     M_DATA,
  output logic              M_LAST,
  output logic [LGFLEN:0]   o_fill,
  output logic [LGFLEN:0]   o_packets,
  output logic              o_drop
);

  localparam int unsigned AW   = LGFLEN + 1;
  localparam int unsigned FLEN = 1 << LGFLEN;

  typedef enum logic [1:0] {IDLE, PKT, DISCARD} state_t;

  state_t          r_state, w_state_nxt;
  logic [AW-1:0]   r_wr_addr, r_wr_commit, r_rd_addr;
  logic [AW-1:0]   w_wr_addr_nxt, w_wr_commit_nxt, w_rd_addr_nxt;
  logic [AW-1:0]   w_fill_nxt, w_packets_nxt;
  logic            r_full;
  logic            w_committed_empty, w_wr_accept, w_rd, w_rd_last;
  logic            w_mem_we, w_commit, w_rollback, w_drop_nxt;
  logic [BW:0]     r_mem [FLEN];

  // Handshake qualifiers; overflow is only possible with nothing committed
  assign w_committed_empty = (r_wr_commit == r_rd_addr);
  assign S_READY           = (r_state == DISCARD) || !r_full || w_committed_empty;
  assign M_VALID           = !w_committed_empty;
  assign w_wr_accept       = S_VALID && S_READY;
  assign w_rd              = M_VALID && M_READY;
  assign w_rd_last         = w_rd && M_LAST;

  // First-word fall-through read port
  assign {M_LAST, M_DATA} = r_mem[r_rd_addr[LGFLEN-1:0]];

  // Write-side next state, pointer updates and fill/packet bookkeeping
  always_comb begin
    w_state_nxt     = r_state;
    w_wr_addr_nxt   = r_wr_addr;
    w_wr_commit_nxt = r_wr_commit;
    w_mem_we        = 1'b0;
    w_commit        = 1'b0;
    w_rollback      = 1'b0;
    w_drop_nxt      = 1'b0;

    if (S_ABORT) begin
      w_rollback  = 1'b1;
      w_state_nxt = IDLE;
      w_drop_nxt  = (r_state != IDLE);
    end else if (w_wr_accept) begin
      if (r_state == DISCARD) begin
        if (S_LAST) w_state_nxt = IDLE;
      end else if (!r_full) begin
        w_mem_we      = 1'b1;
        w_wr_addr_nxt = r_wr_addr + AW'(1);
        if (S_LAST) begin
          w_commit        = 1'b1;
          w_wr_commit_nxt = r_wr_addr + AW'(1);
          w_state_nxt     = IDLE;
        end else begin
          w_state_nxt = PKT;
        end
      end else begin
        w_rollback  = 1'b1;
        w_drop_nxt  = 1'b1;
        w_state_nxt = S_LAST ? IDLE : DISCARD;
      end
    end

    if (w_rollback) w_wr_addr_nxt = r_wr_commit;

    w_rd_addr_nxt = r_rd_addr + AW'(w_rd);
    if (w_rollback) w_fill_nxt = r_wr_commit - w_rd_addr_nxt;
    else            w_fill_nxt = o_fill + AW'(w_mem_we) - AW'(w_rd);
    w_packets_nxt = o_packets + AW'(w_commit) - AW'(w_rd_last);
  end

  // State, pointer and status registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_wr_addr   <= '0;
      r_wr_commit <= '0;
      r_rd_addr   <= '0;
      r_full      <= 1'b0;
      o_fill      <= '0;
      o_packets   <= '0;
      o_drop      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_wr_addr   <= w_wr_addr_nxt;
      r_wr_commit <= w_wr_commit_nxt;
      r_rd_addr   <= w_rd_addr_nxt;
      r_full      <= (w_fill_nxt == AW'(FLEN));
      o_fill      <= w_fill_nxt;
      o_packets   <= w_packets_nxt;
      o_drop      <= w_drop_nxt;
    end
  end

  // Packet storage, data plus last flag
  always_ff @(posedge i_clk) begin
    if (w_mem_we && !i_reset) r_mem[r_wr_addr[LGFLEN-1:0]] <= {S_LAST, S_DATA};
  end

endmodule
